// File: rtl/queue_ctrl.sv
// Circular-FIFO controller for a queue whose storage lives in an external register file.
// Optional build macro QUEUE_EDGE_DETECT_EN turns enq/deq into edge-detected button inputs.
module queue_ctrl #(
  parameter int dataWidth = 4,
  parameter int addressN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq,
  input  logic                 deq,
  input  logic [dataWidth-1:0] in,
  output logic [dataWidth-1:0] out,
  output logic                 out_valid,
  output logic                 full,
  output logic                 empty,
  output logic [addressN:0]    count,
  output logic                 ovf,
  output logic                 udf,
  output logic [addressN-1:0]  rf_wa,
  output logic [dataWidth-1:0] rf_wd,
  output logic                 rf_we,
  output logic [addressN-1:0]  rf_ra0,
  input  logic [dataWidth-1:0] rf_rd0
);

  localparam int DEPTH = 2 ** addressN;
  localparam logic [addressN:0]   DEPTH_C = (addressN + 1)'(DEPTH);
  localparam logic [addressN-1:0] PTR_ONE = {{(addressN - 1){1'b0}}, 1'b1};
  localparam logic [addressN:0]   CNT_ONE = {{addressN{1'b0}}, 1'b1};

  logic [addressN-1:0]  head_q, head_d, tail_q, tail_d;
  logic [addressN:0]    count_q, count_d;
  logic [dataWidth-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic                 e_s, d_s, full_s, empty_s, enq_acc_s, deq_acc_s;

`ifdef QUEUE_EDGE_DETECT_EN
  logic prev_enq_q, prev_deq_q;

  // Previous button levels, so a held button yields a single request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_enq_q <= 1'b0;
      prev_deq_q <= 1'b0;
    end else begin
      prev_enq_q <= enq;
      prev_deq_q <= deq;
    end
  end

  assign e_s = enq & ~prev_enq_q;
  assign d_s = deq & ~prev_deq_q;
`else
  assign e_s = enq;
  assign d_s = deq;
`endif

  assign full_s    = (count_q == DEPTH_C);
  assign empty_s   = (count_q == '0);
  // A full queue still takes a write when the same edge frees the head slot.
  assign enq_acc_s = e_s & (~full_s | d_s);
  assign deq_acc_s = d_s & ~empty_s;

  // Next-state for pointers, occupancy, dequeued data and sticky error flags.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    if (enq_acc_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (deq_acc_s) begin
      head_d      = head_q + PTR_ONE;
      out_d       = rf_rd0;
      out_valid_d = 1'b1;
    end else begin
      head_d      = head_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
    end

    case ({enq_acc_s, deq_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (e_s & full_s & ~d_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (d_s & empty_s) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_q;
    end
  end

  // State registers; reset discards queue contents logically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign rf_wa     = tail_q;
  assign rf_wd     = in;
  assign rf_we     = enq_acc_s;
  assign rf_ra0    = head_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl: directed stimulus pushes expected dequeue data,
// a monitor pops and compares whenever out_valid pulses.
module tb_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst, enq, deq;
  logic [3:0] in, out, rf_wd, rf_rd0, count;
  logic       out_valid, full, empty, ovf, udf, rf_we;
  logic [2:0] rf_wa, rf_ra0;

  logic [3:0] mem [8];
  logic [3:0] exp_q [$];
  logic [3:0] v, last_out;
  int vectors = 0;
  int miscompares = 0;

  queue_ctrl #(.dataWidth(4), .addressN(3)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .in(in),
    .out(out), .out_valid(out_valid), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .rf_ra0(rf_ra0),
    .rf_rd0(rf_rd0)
  );

  always #5 clk = ~clk;

  // Register file model: reset clears entry 0 only, combinational read port.
  always @(posedge clk or posedge rst) begin
    if (rst) mem[0] <= 4'h0;
    else if (rf_we) mem[rf_wa] <= rf_wd;
  end
  assign rf_rd0 = mem[rf_ra0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected dequeue value.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got out=%0d expected no output", out);
      end else begin
        chk("deq_data", out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input logic e, input logic d, input logic [3:0] data);
    @(negedge clk);
    enq = e;
    deq = d;
    in  = data;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enq = 1'b0;
    deq = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; in = 4'h0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef QUEUE_EDGE_DETECT_EN
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4'd6);
    tick(1'b0, 1'b0, 4'd0);
    chk("hold_enq_count", count, 1);
    exp_q.push_back(4'd6);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    chk("hold_deq_count", count, 0);
    chk("hold_deq_udf", udf, 0);
`else
    // Enqueue 1,2,3.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'(i + 1));
      chk("enq_we", rf_we, 1);
      chk("enq_wa", rf_wa, i);
      chk("enq_wd", rf_wd, i + 1);
    end
    tick(1'b0, 1'b0, 4'd0);
    chk("enq3_count", count, 3);
    chk("enq3_empty", empty, 0);
    chk("idle_we", rf_we, 0);

    // Dequeue three.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 4'd0);
      chk("deq_ra0", rf_ra0, i);
      exp_q.push_back(4'(i + 1));
    end
    tick(1'b0, 1'b0, 4'd0);
    chk("deq3_count", count, 0);
    chk("deq3_empty", empty, 1);
    tick(1'b0, 1'b0, 4'd0);
    chk("deq3_out_valid_low", out_valid, 0);
    chk("deq3_out_hold", out, 3);

    // Fill to DEPTH, overflow attempt, then simultaneous enq/deq while full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 4'(i + 5));
      chk("fill_wa", rf_wa, i);
    end
    tick(1'b1, 1'b0, 4'd15);
    chk("full_flag", full, 1);
    chk("full_count", count, 8);
    chk("full_enq_rejected", rf_we, 0);
    tick(1'b0, 1'b0, 4'd0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 8);
    chk("ovf_no_udf", udf, 0);
    tick(1'b1, 1'b1, 4'd14);
    chk("full_ed_we", rf_we, 1);
    chk("full_ed_wa", rf_wa, 0);
    chk("full_ed_ra0", rf_ra0, 0);
    exp_q.push_back(4'd5);
    tick(1'b0, 1'b0, 4'd0);
    chk("full_ed_count", count, 8);
    chk("full_ed_full", full, 1);
    chk("full_ed_tail", rf_wa, 1);
    chk("full_ed_head", rf_ra0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 4'd0);
      chk("drain_count", count, 8 - i);
      exp_q.push_back((i < 7) ? 4'(i + 6) : 4'd14);
    end
    tick(1'b0, 1'b0, 4'd0);
    chk("drain_empty", empty, 1);

    // Alternate enqueue/dequeue across pointer wrap.
    v = 4'd0;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        v = 4'((k * 3 + 1) % 16);
        tick(1'b1, 1'b0, v);
        chk("alt_count0", count, 0);
        chk("alt_wa", rf_wa, (1 + k / 2) % 8);
      end else begin
        tick(1'b0, 1'b1, 4'd0);
        chk("alt_count1", count, 1);
        chk("alt_ra0", rf_ra0, (1 + k / 2) % 8);
        exp_q.push_back(v);
      end
    end
    last_out = 4'd7;
    tick(1'b0, 1'b0, 4'd0);
    chk("alt_end_count", count, 0);

    // Underflow, then enq+deq on empty.
    tick(1'b0, 1'b1, 4'd0);
    chk("udf_no_we", rf_we, 0);
    tick(1'b0, 1'b0, 4'd0);
    chk("udf_set", udf, 1);
    chk("udf_count", count, 0);
    chk("udf_out_hold", out, last_out);
    chk("udf_no_valid", out_valid, 0);
    tick(1'b1, 1'b1, 4'd9);
    chk("empty_ed_we", rf_we, 1);
    tick(1'b0, 1'b0, 4'd0);
    chk("empty_ed_count", count, 1);
    chk("empty_ed_udf", udf, 1);
    chk("empty_ed_no_valid", out_valid, 0);

    // Build count=5 and reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 4'(i + 2));
    tick(1'b0, 1'b0, 4'd0);
    chk("pre_rst_count", count, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_out", out, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_udf", udf, 0);
    rst = 1'b0;
`endif

    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
